dmux_router: RTL and testbench
==============================

Name: dmux_router

Overview:
- Parametrised, buffered successor to the combinational 4-way 16-bit demultiplexer.
- Routes each accepted input word to one of N = 2**SEL_BITS output channels. Each channel has its own DEPTH-entry FIFO.
- Valid/ready handshakes on the input and on every output, so one stalled consumer blocks only traffic addressed to it.
- Sits between the Hack data path and multiple downstream consumers (memory-mapped devices, screen/keyboard ports).

Parameters:
- WIDTH, 16, data word width in bits.
- SEL_BITS, 2, select width; channel count N = 2**SEL_BITS.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  SEL_BITS  destination channel index.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  router accepts the word this cycle.
- out_data  output  WIDTH*N  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  N  bit k: channel k FIFO non-empty.
- out_ready  input  N  bit k: consumer k pops this cycle.
- occupancy  output  N*(log2(DEPTH)+1)  per-channel entry count, channel k in slice k.

Behaviour:
- Reset (async, active-high, immediate):
  - all FIFO pointers and counts = 0;
  - out_valid = 0; out_data = 0; occupancy = 0;
  - in_ready = 1 once reset deasserts.
- Push:
  - accept = in_valid && in_ready.
  - On accept, in_data is written into FIFO[in_sel] at its write pointer; write pointer increments modulo DEPTH.
- Pop:
  - pop[k] = out_valid[k] && out_ready[k]; read pointer k increments modulo DEPTH.
  - out_ready[k] while out_valid[k]=0 is ignored.
- in_ready = (count[in_sel] < DEPTH) || out_ready[in_sel]. This allows push into a full FIFO when it is popped in the same cycle.
  - in_ready depends combinationally on in_sel and out_ready; it must not depend on in_valid.
- count[k] next value:
  - +1 on push only;
  - -1 on pop only;
  - unchanged when push and pop occur together on k, or when neither occurs.
- out_valid[k] = (count[k] != 0).
- out_data slice k:
  - head entry of FIFO k when non-empty;
  - all zeros when empty (dmux semantics: unselected/idle outputs read 0).
- Latency: a word accepted on edge t appears on out_data slice in_sel with out_valid set after edge t. There is no combinational in->out path.
- Ordering: per-channel FIFO order preserved. No ordering guarantee across channels.
- Empty + push + out_ready high same cycle: the word is not bypassed; it becomes visible next cycle.
- Wrap-around: pointers wrap at DEPTH with no bubble; count saturates logically at DEPTH, since in_ready prevents overflow.
- Reset mid-operation: all buffered words are discarded; outputs return to 0 asynchronously.
- Only the addressed channel changes on a push; other channels' data and counts are untouched.

Optional Feature:
- Macro: DMUX_ROUTER_DROP_EN.
- Defined:
  - in_ready is tied to 1.
  - A push to a full channel that is not popping that cycle is discarded: FIFO is unchanged.
  - The discard increments a 16-bit saturating counter, exposed on extra output port drop_cnt (output, 16). drop_cnt resets to 0.
- Undefined:
  - No drop_cnt port exists.
  - Backpressure behaves as specified above; no word is ever lost.

Test Plan:
- Reset-then-route:
  - Stimulus: assert reset; release; push 16'h0001 with in_sel=0,1,2,3 on consecutive cycles, all out_ready=0.
  - Required response: each out_data slice equals 16'h0001 with out_valid=4'b1111 after the pushes; all slices 0 before.
- Full backpressure:
  - Stimulus: DEPTH=2, push 16'hAAAA and 16'h5555 to channel 2, out_ready=0.
  - Required response: occupancy[2]=2 and in_ready=0 for in_sel=2; in_ready=1 for in_sel=0.
- Simultaneous push/pop on full:
  - Stimulus: channel 2 full, out_ready[2]=1, push 16'h1234.
  - Required response: accepted; count stays 2; head becomes 16'h5555, then 16'h1234 after next pop.
- Drain and zero:
  - Stimulus: pop channel 2 until empty.
  - Required response: out_valid[2]=0; slice 2 reads 16'h0000; pointers have wrapped with data still in FIFO order.
- Async reset mid-traffic:
  - Stimulus: with three channels occupied, pulse reset between clock edges.
  - Required response: out_valid=0, out_data=0 immediately, without waiting for a clock edge.
- DMUX_ROUTER_DROP_EN:
  - Stimulus: push 3 words to full channel 1 with out_ready=0.
  - Required response: drop_cnt=3; FIFO contents unchanged; in_ready stays 1.

Source files
------------

// File: rtl/dmux_router.sv
// Buffered valid/ready demultiplexer: routes each input word to one of 2**SEL_BITS per-channel FIFOs.
// Optional macro DMUX_ROUTER_DROP_EN: in_ready tied high, pushes to a full channel are dropped and counted on drop_cnt.
module dmux_router #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SEL_BITS = 2,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [WIDTH-1:0]                               in_data,
    input  logic [SEL_BITS-1:0]                            in_sel,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    output logic [WIDTH*(2**SEL_BITS)-1:0]                 out_data,
    output logic [(2**SEL_BITS)-1:0]                       out_valid,
    input  logic [(2**SEL_BITS)-1:0]                       out_ready,
    output logic [(2**SEL_BITS)*($clog2(DEPTH)+1)-1:0]     occupancy
`ifdef DMUX_ROUTER_DROP_EN
    ,
    output logic [15:0]                                    drop_cnt
`endif
);

    localparam int unsigned N  = 2**SEL_BITS;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [N][DEPTH];
    logic [PW-1:0]    wr_ptr_q [N];
    logic [PW-1:0]    wr_ptr_d [N];
    logic [PW-1:0]    rd_ptr_q [N];
    logic [PW-1:0]    rd_ptr_d [N];
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];

    logic [N-1:0]     pop_c;
    logic [N-1:0]     push_vec_c;
    logic             push_c;
    logic             full_c;
    logic             sel_pop_c;

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            pop_c[k] = (cnt_q[k] != '0) && out_ready[k];
        end
    end

    // A full channel still takes a word when it pops in the same cycle.
    always_comb begin
        full_c    = (cnt_q[in_sel] == CW'(DEPTH));
        sel_pop_c = pop_c[in_sel];
`ifdef DMUX_ROUTER_DROP_EN
        in_ready  = 1'b1;
`else
        in_ready  = !full_c || out_ready[in_sel];
`endif
        push_c     = in_valid && in_ready && (!full_c || sel_pop_c);
        push_vec_c = '0;
        if (push_c) begin
            push_vec_c[in_sel] = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            cnt_d[k]    = cnt_q[k];
            if (push_vec_c[k]) begin
                wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
            end
            if (pop_c[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            end
            case ({push_vec_c[k], pop_c[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < N; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
        end
    end

    // Storage needs no reset: visibility is gated by the per-channel count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[in_sel][wr_ptr_q[in_sel]] <= in_data;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            out_valid[k]              = (cnt_q[k] != '0);
            out_data[k*WIDTH +: WIDTH] = (cnt_q[k] != '0) ? mem_q[k][rd_ptr_q[k]] : '0;
            occupancy[k*CW +: CW]     = cnt_q[k];
        end
    end

`ifdef DMUX_ROUTER_DROP_EN
    logic        drop_c;
    logic [15:0] drop_cnt_q;

    assign drop_c   = in_valid && full_c && !sel_pop_c;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmux_router.sv
// Scoreboard bench for dmux_router: per-channel expected-word queues, directed scenarios then random traffic.
module tb_dmux_router;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned SEL_BITS = 2;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned N        = 4;
    localparam int unsigned CW       = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WIDTH-1:0]      in_data;
    logic [SEL_BITS-1:0]   in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH*N-1:0]    out_data;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          out_ready;
    logic [N*CW-1:0]       occupancy;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [WIDTH-1:0] expq [N][$];

    dmux_router #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, check in_ready against the queue model, record accepted word after the edge.
    task automatic cycle(input logic v, input logic [SEL_BITS-1:0] s, input logic [WIDTH-1:0] d,
                         input logic [N-1:0] r);
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_rdy = (expq[s].size() < DEPTH) || r[s];
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc) expq[s].push_back(d);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = '0;
        #2;
        reset = 1'b1;
        for (int k = 0; k < N; k++) expq[k].delete();
        #1;
        check("async_rst_valid", {60'd0, out_valid}, 64'd0);
        check("async_rst_data", out_data, 64'd0);
        check("async_rst_occ", {56'd0, occupancy}, 64'd0);
        reset = 1'b0;
    endtask

    // Monitor: just before each rising edge, compare every channel with the model and retire handshaked words.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                for (int k = 0; k < N; k++) begin
                    automatic logic [WIDTH-1:0] sl  = out_data[k*WIDTH +: WIDTH];
                    automatic int               sz  = expq[k].size();
                    automatic logic [CW-1:0]    occ = occupancy[k*CW +: CW];
                    check("occupancy", {62'd0, occ}, 64'(sz));
                    check("out_valid", {63'd0, out_valid[k]}, {63'd0, sz != 0});
                    if (sz == 0) begin
                        check("idle_zero", {48'd0, sl}, 64'd0);
                    end else begin
                        check("head_data", {48'd0, sl}, {48'd0, expq[k][0]});
                        if (out_ready[k]) void'(expq[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {60'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_occupancy", {56'd0, occupancy}, 64'd0);
        mon_en = 1'b1;

        // Route the same word to every channel, then drain.
        for (int s = 0; s < N; s++) cycle(1'b1, SEL_BITS'(s), 16'h0001, 4'b0000);
        cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
        check("route_all_valid", {60'd0, out_valid}, 64'h000F);
        cycle(1'b0, 2'd0, 16'h0000, 4'b1111);

        // Fill channel 2, try an extra push, confirm other channels still accept.
        cycle(1'b1, 2'd2, 16'hAAAA, 4'b0000);
        cycle(1'b1, 2'd2, 16'h5555, 4'b0000);
        cycle(1'b1, 2'd2, 16'hDEAD, 4'b0000);
        cycle(1'b1, 2'd0, 16'h0BEE, 4'b0000);

        // Push into full channel 2 while it pops, then drain through the wrap.
        cycle(1'b1, 2'd2, 16'h1234, 4'b0100);
        cycle(1'b0, 2'd2, 16'h0000, 4'b0100);
        cycle(1'b0, 2'd2, 16'h0000, 4'b0100);
        cycle(1'b0, 2'd2, 16'h0000, 4'b0100);
        cycle(1'b0, 2'd0, 16'h0000, 4'b0001);

        // Empty channel with out_ready high: word is not bypassed.
        cycle(1'b1, 2'd1, 16'hC0DE, 4'b0010);
        cycle(1'b0, 2'd1, 16'h0000, 4'b0010);

        // Occupy three channels, then reset between edges.
        cycle(1'b1, 2'd0, 16'h1111, 4'b0000);
        cycle(1'b1, 2'd1, 16'h2222, 4'b0000);
        cycle(1'b1, 2'd3, 16'h3333, 4'b0000);
        cycle(1'b1, 2'd3, 16'h4444, 4'b0000);
        reset_pulse();
        cycle(1'b1, 2'd3, 16'h5A5A, 4'b0000);

        // Random traffic with biased backpressure.
        for (int i = 0; i < 3000; i++) begin
            automatic logic [N-1:0] r;
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 2) != 0);
            cycle(($urandom_range(0, 3) != 0), SEL_BITS'($urandom_range(0, N - 1)),
                  WIDTH'($urandom), r);
        end

        repeat (DEPTH * N + 4) cycle(1'b0, 2'd0, 16'h0000, 4'b1111);
        for (int k = 0; k < N; k++) check("drained", 64'(expq[k].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
